// File: rtl/otn_mapper.sv
// otn_mapper: sender-side OTN framer/mapper, serializes FAS + MFAS + payload (+ optional BIP-8) MSB-first
// Ports:
//   i_clk, i_rst                  clock, asynchronous active-high reset
//   i_pld_data/i_pld_valid/o_pld_ready  client payload byte stream (ready/valid)
//   i_fifo_ready                  downstream FIFO accepts a bit this cycle
//   o_frame_data/o_frame_data_valid/o_frame_data_fas  registered serial bit, its valid, FAS marker
// Optional feature: define OTN_MAPPER_BIP8_EN to append a BIP-8 byte over the payload.
module otn_mapper #(
    parameter int          PAYLOAD_BYTES = 16,
    parameter logic [47:0] FAS_PATTERN   = 48'hF6F6F6282828
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [7:0] i_pld_data,
    input  logic       i_pld_valid,
    output logic       o_pld_ready,
    input  logic       i_fifo_ready,
    output logic       o_frame_data,
    output logic       o_frame_data_valid,
    output logic       o_frame_data_fas
);
    localparam int BW = $clog2(PAYLOAD_BYTES > 6 ? PAYLOAD_BYTES : 6);

    typedef enum logic [2:0] {
        IDLE,
        FAS,
        MFAS,
`ifdef OTN_MAPPER_BIP8_EN
        PLD,
        BIP
`else
        PLD
`endif
    } state_t;

    state_t        state_q;
    logic [BW-1:0] byte_idx_q;
    logic [2:0]    bit_idx_q;
    logic [7:0]    mfas_q;
    logic [7:0]    pld_q;
`ifdef OTN_MAPPER_BIP8_EN
    logic [7:0]    bip_q;
`endif
    logic          data_q;
    logic          valid_q;
    logic          fas_q;

    logic          adv;
    logic          cur_bit;
    logic          bit0;
    logic          last_byte;
    logic [7:0]    pld_byte;
    logic [5:0]    fas_idx;

    always_comb begin
        bit0      = bit_idx_q == 3'd0;
        last_byte = byte_idx_q == BW'(PAYLOAD_BYTES - 1);
        // {byte,bit} is 8*byte+bit; FAS is at most 6 bytes so 3 byte bits suffice
        fas_idx   = 6'd47 - {byte_idx_q[2:0], bit_idx_q};
        // the first payload bit goes straight from the client bus, later bits from the captured byte
        pld_byte  = bit0 ? i_pld_data : pld_q;
        adv       = i_fifo_ready && state_q != IDLE && !(state_q == PLD && bit0 && !i_pld_valid);
`ifdef OTN_MAPPER_BIP8_EN
        cur_bit   = state_q == FAS  ? FAS_PATTERN[fas_idx] :
                    state_q == MFAS ? mfas_q[~bit_idx_q] :
                    state_q == PLD  ? pld_byte[~bit_idx_q] : bip_q[~bit_idx_q];
`else
        cur_bit   = state_q == FAS  ? FAS_PATTERN[fas_idx] :
                    state_q == MFAS ? mfas_q[~bit_idx_q] : pld_byte[~bit_idx_q];
`endif
    end

    assign o_pld_ready        = state_q == PLD && bit0 && i_fifo_ready;
    assign o_frame_data       = data_q;
    assign o_frame_data_valid = valid_q;
    assign o_frame_data_fas   = fas_q;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q    <= IDLE;
            byte_idx_q <= '0;
            bit_idx_q  <= '0;
            mfas_q     <= '0;
            pld_q      <= '0;
`ifdef OTN_MAPPER_BIP8_EN
            bip_q      <= '0;
`endif
            data_q     <= 1'b0;
            valid_q    <= 1'b0;
            fas_q      <= 1'b0;
        end else begin
            valid_q <= adv;
            fas_q   <= adv && state_q == FAS;
            if (state_q == IDLE) begin
                if (i_pld_valid) state_q <= FAS;
            end else if (adv) begin
                data_q    <= cur_bit;
                bit_idx_q <= bit_idx_q + 3'd1;
                if (state_q == PLD && bit0) begin
                    pld_q <= i_pld_data;
`ifdef OTN_MAPPER_BIP8_EN
                    bip_q <= bip_q ^ i_pld_data;
`endif
                end
                if (bit_idx_q == 3'd7) begin
                    case (state_q)
                        FAS: begin
                            byte_idx_q <= byte_idx_q == BW'(5) ? '0 : byte_idx_q + BW'(1);
                            if (byte_idx_q == BW'(5)) state_q <= MFAS;
                        end
                        MFAS: state_q <= PLD;
                        PLD: begin
                            byte_idx_q <= last_byte ? '0 : byte_idx_q + BW'(1);
                            if (last_byte) begin
`ifdef OTN_MAPPER_BIP8_EN
                                state_q <= BIP;
`else
                                mfas_q  <= mfas_q + 8'd1;
                                state_q <= i_pld_valid ? FAS : IDLE;
`endif
                            end
                        end
`ifdef OTN_MAPPER_BIP8_EN
                        BIP: begin
                            mfas_q  <= mfas_q + 8'd1;
                            bip_q   <= '0;
                            state_q <= i_pld_valid ? FAS : IDLE;
                        end
`endif
                        default: ;
                    endcase
                end
            end
        end
    end
endmodule

// File: tb/tb_otn_mapper.sv
// tb_otn_mapper: directed self-checking bench for otn_mapper (PAYLOAD_BYTES=16)
module tb_otn_mapper;
    localparam int PB = 16;
    localparam logic [47:0] FAS = 48'hF6F6F6282828;
`ifdef OTN_MAPPER_BIP8_EN
    localparam int FL = 8 * (8 + PB);
`else
    localparam int FL = 8 * (7 + PB);
`endif
    localparam int NPAT = 257 * PB;

    logic       i_clk = 1'b0;
    logic       i_rst;
    logic [7:0] i_pld_data;
    logic       i_pld_valid;
    logic       o_pld_ready;
    logic       i_fifo_ready;
    logic       o_frame_data;
    logic       o_frame_data_valid;
    logic       o_frame_data_fas;

    otn_mapper #(.PAYLOAD_BYTES(PB), .FAS_PATTERN(FAS)) dut (
        .i_clk(i_clk),
        .i_rst(i_rst),
        .i_pld_data(i_pld_data),
        .i_pld_valid(i_pld_valid),
        .o_pld_ready(o_pld_ready),
        .i_fifo_ready(i_fifo_ready),
        .o_frame_data(o_frame_data),
        .o_frame_data_valid(o_frame_data_valid),
        .o_frame_data_fas(o_frame_data_fas)
    );

    always #5 i_clk = ~i_clk;

    int         n_checks = 0;
    int         n_errors = 0;
    int         cyc = 0;
    int         rise_cyc = -1;
    int         avail = 0;
    int         rd = 0;
    logic       fire;
    logic [7:0] pat [0:NPAT-1];
    logic       rx_q[$];
    logic       rxf_q[$];
    int         rxc_q[$];
    logic       ref_q[$];

    always @(posedge i_clk) cyc <= cyc + 1;

    // payload source: byte rd of pat is offered while rd < avail
    initial begin
        i_pld_valid = 1'b0;
        i_pld_data  = 8'h00;
        forever begin
            @(negedge i_clk);
            fire = o_pld_ready && i_pld_valid;
            @(posedge i_clk);
            #1;
            if (i_rst) rd = 0;
            else if (fire) rd = rd + 1;
            i_pld_valid = rd < avail;
            i_pld_data  = rd < avail ? pat[rd] : 8'h00;
        end
    end

    // output monitor: collects valid bits, FAS flags and the cycle each bit appeared
    always @(negedge i_clk) begin
        if (i_rst) begin
            rx_q.delete();
            rxf_q.delete();
            rxc_q.delete();
            rise_cyc <= -1;
        end else begin
            if (o_frame_data_valid) begin
                rx_q.push_back(o_frame_data);
                rxf_q.push_back(o_frame_data_fas);
                rxc_q.push_back(cyc);
            end
            if (i_pld_valid && rise_cyc < 0) rise_cyc <= cyc;
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] rx_byte(input int s);
        logic [7:0] b = 8'h00;
        for (int i = 0; i < 8; i++) b = {b[6:0], rx_q[s+i]};
        return b;
    endfunction

    function automatic logic [47:0] rx_word48(input int s);
        logic [47:0] w = '0;
        for (int i = 0; i < 48; i++) w = {w[46:0], rx_q[s+i]};
        return w;
    endfunction

    function automatic int gaps(input int s, input int n);
        return rxc_q[s+n-1] - rxc_q[s] + 1 - n;
    endfunction

    task automatic wait_bits(input string tag, input int n, input int budget);
        int t = 0;
        while (rx_q.size() < n && t < budget) begin
            @(negedge i_clk);
            t++;
        end
        #1;
        if (rx_q.size() < n) check({tag, "_timeout"}, rx_q.size(), n);
    endtask

    task automatic do_reset();
        i_rst = 1'b1;
        avail = 0;
        i_fifo_ready = 1'b1;
        repeat (3) @(negedge i_clk);
        @(posedge i_clk);
        #1;
        i_rst = 1'b0;
    endtask

    task automatic check_frame(input string tag, input int b, input logic [7:0] mf, input int p);
        int fas_bad = 0;
        int pld_bad = 0;
`ifdef OTN_MAPPER_BIP8_EN
        logic [7:0] x = 8'h00;
`endif
        if (rx_q.size() < b + FL) begin
            check({tag, "_len"}, rx_q.size(), b + FL);
            return;
        end
        for (int i = 0; i < FL; i++) if (rxf_q[b+i] != (i < 48)) fas_bad++;
        check({tag, "_fas"}, rx_word48(b), FAS);
        check({tag, "_fasflag"}, fas_bad, 0);
        check({tag, "_mfas"}, rx_byte(b + 48), mf);
        check({tag, "_byte0"}, rx_byte(b + 56), pat[p]);
        for (int k = 0; k < PB; k++) begin
            if (rx_byte(b + 56 + 8 * k) != pat[p+k]) pld_bad++;
`ifdef OTN_MAPPER_BIP8_EN
            x = x ^ pat[p+k];
`endif
        end
        check({tag, "_pld"}, pld_bad, 0);
`ifdef OTN_MAPPER_BIP8_EN
        check({tag, "_bip"}, rx_byte(b + 56 + 8 * PB), x);
`endif
    endtask

    initial begin
        int found;
        int low_cnt;
        int bad;
        i_rst = 1'b1;
        i_fifo_ready = 1'b1;
        #1;
        check("rst_data", o_frame_data, 0);
        check("rst_valid", o_frame_data_valid, 0);
        check("rst_fas", o_frame_data_fas, 0);
        check("rst_ready", o_pld_ready, 0);

        // basic frame
        for (int i = 0; i < NPAT; i++) pat[i] = 8'(i);
        do_reset();
        avail = PB;
        wait_bits("basic", FL, FL + 100);
        repeat (20) @(negedge i_clk);
        #1;
        check("basic_len", rx_q.size(), FL);
        if (rx_q.size() == FL) begin
            check("basic_latency", rxc_q[0] - rise_cyc, 2);
            check("basic_gaps", gaps(0, FL), 0);
        end
        check_frame("basic", 0, 8'h00, 0);
        ref_q = rx_q;

        // back-to-back frames
        do_reset();
        avail = 2 * PB;
        wait_bits("b2b", 2 * FL, 2 * FL + 100);
        repeat (20) @(negedge i_clk);
        #1;
        check("b2b_len", rx_q.size(), 2 * FL);
        if (rx_q.size() == 2 * FL) check("b2b_gaps", gaps(0, 2 * FL), 0);
        check_frame("b2b_f1", FL, 8'h01, PB);

        // FIFO backpressure during payload byte 3
        do_reset();
        avail = PB;
        wait_bits("bp_pre", 56 + 24 + 3, 200);
        @(posedge i_clk);
        #1;
        i_fifo_ready = 1'b0;
        repeat (5) @(posedge i_clk);
        #1;
        i_fifo_ready = 1'b1;
        wait_bits("bp", FL, FL + 100);
        repeat (20) @(negedge i_clk);
        #1;
        check("bp_len", rx_q.size(), FL);
        if (rx_q.size() == FL && ref_q.size() == FL) begin
            bad = 0;
            for (int i = 0; i < FL; i++) if (rx_q[i] !== ref_q[i]) bad++;
            check("bp_gaps", gaps(0, FL), 5);
            check("bp_stream", bad, 0);
        end

        // payload underrun before byte 4, BIP over 01 00 .. 00
        for (int i = 0; i < PB; i++) pat[i] = i == 0 ? 8'h01 : 8'h00;
        do_reset();
        avail = 4;
        found = 0;
        for (int t = 0; t < 400 && found == 0; t++) begin
            @(negedge i_clk);
            #1;
            found = int'(o_pld_ready && !i_pld_valid);
        end
        check("uf_stall", found, 1);
        low_cnt = 0;
        for (int t = 0; t < 10; t++) begin
            @(negedge i_clk);
            #1;
            if (!o_pld_ready) low_cnt++;
        end
        check("uf_ready_held", low_cnt, 0);
        avail = PB;
        wait_bits("uf", FL, FL + 100);
        repeat (20) @(negedge i_clk);
        #1;
        check("uf_len", rx_q.size(), FL);
        if (rx_q.size() == FL) check("uf_gap_ge10", int'(gaps(0, FL) >= 10), 1);
        check_frame("uf", 0, 8'h00, 0);

        // MFAS wrap over 257 frames
        for (int i = 0; i < NPAT; i++) pat[i] = 8'(i);
        do_reset();
        avail = NPAT;
        wait_bits("wrap", 257 * FL, 257 * FL + 500);
        repeat (20) @(negedge i_clk);
        #1;
        check("wrap_len", rx_q.size(), 257 * FL);
        if (rx_q.size() == 257 * FL) begin
            check("wrap_gaps", gaps(0, 257 * FL), 0);
            check("wrap_mfas1", rx_byte(FL + 48), 8'h01);
            check("wrap_mfas255", rx_byte(255 * FL + 48), 8'hFF);
            check("wrap_fasflag_end", rxf_q[FL-1], 0);
            check("wrap_fasflag_start", rxf_q[FL], 1);
        end
        check_frame("wrap_f256", 256 * FL, 8'h00, 256 * PB);

        // reset during MFAS of frame 3
        do_reset();
        avail = 4 * PB;
        wait_bits("mrst_pre", 2 * FL + 50, 2 * FL + 100);
        @(negedge i_clk);
        #2;
        check("mrst_pre_valid", o_frame_data_valid, 1);
        i_rst = 1'b1;
        #1;
        check("mrst_data", o_frame_data, 0);
        check("mrst_valid", o_frame_data_valid, 0);
        check("mrst_fas", o_frame_data_fas, 0);
        check("mrst_ready", o_pld_ready, 0);
        do_reset();
        avail = PB;
        wait_bits("mrst", FL, FL + 100);
        check_frame("mrst", 0, 8'h00, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/otn_mapper.md
# otn_mapper

Sender-side OTN framer/mapper. Accepts client payload bytes over a ready/valid byte interface and builds fixed-length frames: 6-byte FAS, 1-byte MFAS, PAYLOAD_BYTES payload bytes, and an optional BIP-8 byte. Each frame is serialized MSB-first, one bit per cycle, into the transmit/retransmit stage's RX FIFO (`i_frame_data` / `i_frame_data_valid` / `o_fifo_ready` on that stage). FIFO backpressure stalls the serializer without losing bits.

## Interface
Parameters:
- PAYLOAD_BYTES, 16, payload bytes per frame (≥1).
- FAS_PATTERN, 48'hF6F6F6282828, frame alignment word, sent MSB-first.

Ports:
- i_clk  in  1  single clock.
- i_rst  in  1  asynchronous, active-high reset.
- i_pld_data  in  8  client payload byte.
- i_pld_valid  in  1  payload byte available.
- o_pld_ready  out  1  byte accepted this cycle when high together with i_pld_valid.
- i_fifo_ready  in  1  downstream FIFO can accept a bit this cycle.
- o_frame_data  out  1  serialized frame bit, registered.
- o_frame_data_valid  out  1  o_frame_data is valid this cycle, registered.
- o_frame_data_fas  out  1  high while o_frame_data carries one of the 48 FAS bits, registered.

## Operation
- States: IDLE, FAS, MFAS, PLD, BIP (BIP exists only with the macro).
- Internal counters:
  - byte_idx: 0..5 in FAS, 0..PAYLOAD_BYTES-1 in PLD.
  - bit_idx: 0..7, MSB first.
  - mfas: 8-bit frame counter.
  - bip: 8-bit accumulator.
- adv = i_fifo_ready && state≠IDLE && !(state==PLD && bit_idx==0 && !i_pld_valid).
- On adv:
  - o_frame_data ← current bit.
  - o_frame_data_valid ← 1.
  - o_frame_data_fas ← (state==FAS).
  - bit_idx increments; on wrap, byte_idx and state advance.
- When adv is low: o_frame_data_valid ← 0, o_frame_data_fas ← 0, o_frame_data holds its value, and the state is unchanged.
- Current-bit sources:
  - FAS: FAS_PATTERN[47 − (8·byte_idx + bit_idx)].
  - MFAS: mfas[7 − bit_idx].
  - PLD, bit_idx==0: i_pld_data[7] directly; the byte is captured into pld_q.
  - PLD, bit_idx>0: pld_q[7 − bit_idx].
  - BIP: bip[7 − bit_idx].
- Payload handshake:
  - o_pld_ready = (state==PLD) && bit_idx==0 && i_fifo_ready. This is combinational, so there is no ready→valid dependency on the client side.
  - A byte is consumed only on the ready&&valid cycle.
- State transitions:
  - IDLE → FAS when i_pld_valid.
  - FAS → MFAS after the 48th bit.
  - MFAS → PLD after 8 bits.
  - PLD → BIP (or frame end) after the last bit of the last byte.
  - BIP → frame end after 8 bits.
- Frame end:
  - mfas ← mfas + 1 (wraps 8'hFF → 8'h00).
  - bip ← 0.
  - Next state is FAS if i_pld_valid, else IDLE. Back-to-back frames therefore have no gap.
- bip ^= byte on every accepted payload byte. It covers payload bytes only, not FAS or MFAS.

## Timing
- Reset values:
  - o_frame_data, o_frame_data_valid, o_frame_data_fas: 0.
  - state: IDLE.
  - mfas, bip, bit_idx, byte_idx, pld_q: 0.
  - o_pld_ready: 0, because state is IDLE.
- Start-up latency: i_pld_valid rises in IDLE at edge N → state FAS at edge N+1 → first valid bit at edge N+2 (given i_fifo_ready=1).
- Sustained throughput is 1 bit/cycle with no gaps across frames, as long as payload and FIFO space are available.
- Frame length:
  - 8·(7+PAYLOAD_BYTES+1) bits with the macro.
  - 8·(7+PAYLOAD_BYTES) bits without it.
- i_fifo_ready low: no bit is emitted, valid is 0 on the following cycle, and nothing is dropped or duplicated.
- Payload underrun at a byte boundary: the serializer stalls with o_pld_ready held high, valid drops to 0, and byte order is preserved.
- Simultaneous i_fifo_ready low and i_pld_valid high at a boundary: no transfer occurs (o_pld_ready is low).
- Reset asserted mid-frame: asynchronous clear to the reset values. The partial frame is abandoned, and the next frame restarts at FAS with MFAS 0x00.

## Configuration
- OTN_MAPPER_BIP8_EN defined:
  - The BIP state and the bip accumulator are compiled in.
  - The BIP byte follows the payload.
  - With PAYLOAD_BYTES=16, the frame is 192 bits.
- OTN_MAPPER_BIP8_EN undefined:
  - No BIP state or accumulator.
  - PLD ends the frame directly.
  - With PAYLOAD_BYTES=16, the frame is 184 bits.

## Test plan
All scenarios use PAYLOAD_BYTES=16.
- Basic frame: i_fifo_ready=1, bytes 0x00..0x0F presented continuously from reset → valid first high 2 cycles after i_pld_valid. The response must be:
  - 48 bits matching F6F6F6282828 with fas=1.
  - MFAS 0x00.
  - Payload 0x00..0x0F.
  - BIP 0x00.
  - 192 contiguous valid cycles in total.
- Back-to-back frames: payload kept valid for 2 frames → no valid gap between frames, and the second MFAS is 0x01.
- Backpressure: i_fifo_ready low for 5 cycles during payload byte 3 → exactly 5 valid-low cycles, and the reassembled stream is identical to the unstalled reference.
- Underrun and BIP: i_pld_valid low for 10 cycles before byte 4, with payload byte0=0x01 and all others 0x00 → o_pld_ready stays high through the gap, 10+ cycles of valid low, bytes in order, BIP 0x01.
- MFAS wrap, and build without the macro: 257 frames → frame 256 MFAS 0xFF, frame 257 MFAS 0x00. In the build without the macro, each frame is 184 bits and has no BIP byte.
- Reset mid-frame: assert i_rst during the MFAS of frame 3 → all outputs 0 immediately. The next frame starts with the FAS and MFAS 0x00.
